// File: rtl/pe_load_scheduler.sv
// Load scheduler between the PE depacketizer and the scratchpads/compute core.
// Steers rows into the filter/ifmap scratchpads, then sequences one compute per timestep.
module pe_load_scheduler #(
    parameter int unsigned FILTER_WIDTH = 8,
    parameter int unsigned NUM_ROWS     = 3,
    parameter int unsigned TIMESTEPS    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_ifmapb_filter,
    input  logic [1:0]                in_filter_row,
    input  logic                      in_timestep,
    input  logic [3*FILTER_WIDTH-1:0] in_data,
    output logic                      filt_we,
    output logic                      ifmap_we,
    output logic [1:0]                wr_row,
    output logic [3*FILTER_WIDTH-1:0] wr_data,
    output logic                      comp_start,
    output logic                      comp_timestep,
    input  logic                      comp_done,
    output logic                      busy,
    output logic                      err
);

    typedef enum logic [1:0] {LOAD, START, WAIT} state_t;

    localparam logic [NUM_ROWS-1:0] ALL_ROWS  = '1;
    localparam logic [2:0]          ROW_LIMIT = 3'(NUM_ROWS);
    localparam logic                LAST_TS   = 1'(TIMESTEPS - 1);

    state_t              state;
    logic                cur_ts;
    logic [NUM_ROWS-1:0] filt_mask;
    logic [NUM_ROWS-1:0] ifmap_mask;
    logic [NUM_ROWS-1:0] row_bit;
    logic                complete;
    logic                accept;
    logic                legal;

    always_comb begin
        row_bit = '0;
        for (int unsigned i = 0; i < NUM_ROWS; i++) begin
            if (in_filter_row == 2'(i)) row_bit[i] = 1'b1;
        end
    end

    assign complete = (filt_mask == ALL_ROWS) && (ifmap_mask == ALL_ROWS);
    // Gated by rst_n so the handshake reads 0 while reset is held.
    assign in_ready = rst_n && (state == LOAD) && !complete;
    assign accept   = in_valid && in_ready;
    assign legal    = ({1'b0, in_filter_row} < ROW_LIMIT) &&
                      (in_ifmapb_filter || (in_timestep == cur_ts));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= LOAD;
            cur_ts        <= 1'b0;
            filt_mask     <= '0;
            ifmap_mask    <= '0;
            filt_we       <= 1'b0;
            ifmap_we      <= 1'b0;
            wr_row        <= '0;
            wr_data       <= '0;
            comp_start    <= 1'b0;
            comp_timestep <= 1'b0;
            busy          <= 1'b0;
            err           <= 1'b0;
        end else begin
            filt_we    <= 1'b0;
            ifmap_we   <= 1'b0;
            err        <= 1'b0;
            comp_start <= 1'b0;
            unique case (state)
                LOAD: begin
                    if (complete) begin
                        state         <= START;
                        comp_start    <= 1'b1;
                        comp_timestep <= cur_ts;
                        busy          <= 1'b1;
                    end else if (accept) begin
                        if (legal) begin
                            wr_row  <= in_filter_row;
                            wr_data <= in_data;
                            if (in_ifmapb_filter) begin
                                filt_we   <= 1'b1;
                                filt_mask <= filt_mask | row_bit;
                            end else begin
                                ifmap_we   <= 1'b1;
                                ifmap_mask <= ifmap_mask | row_bit;
                            end
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                START: state <= WAIT;
                WAIT: begin
                    if (comp_done) begin
                        state      <= LOAD;
                        busy       <= 1'b0;
                        ifmap_mask <= '0;
                        // Filter rows survive across timesteps; a new layer reloads them.
                        if (cur_ts == LAST_TS) begin
                            cur_ts    <= 1'b0;
                            filt_mask <= '0;
                        end else begin
                            cur_ts <= cur_ts + 1'b1;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_load_scheduler.sv
// Bench for pe_load_scheduler: directed scenarios plus random traffic,
// checked every cycle against a row-presence reference model.
module tb_pe_load_scheduler;

    localparam int FW        = 8;
    localparam int NUM_ROWS  = 3;
    localparam int TIMESTEPS = 2;
    localparam int DW        = 3 * FW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, in_ifmapb_filter, in_timestep;
    logic [1:0]    in_filter_row;
    logic [DW-1:0] in_data;
    logic          filt_we, ifmap_we, comp_start, comp_timestep, comp_done, busy, err;
    logic [1:0]    wr_row;
    logic [DW-1:0] wr_data;

    pe_load_scheduler #(
        .FILTER_WIDTH (FW),
        .NUM_ROWS     (NUM_ROWS),
        .TIMESTEPS    (TIMESTEPS)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_ifmapb_filter (in_ifmapb_filter),
        .in_filter_row    (in_filter_row),
        .in_timestep      (in_timestep),
        .in_data          (in_data),
        .filt_we          (filt_we),
        .ifmap_we         (ifmap_we),
        .wr_row           (wr_row),
        .wr_data          (wr_data),
        .comp_start       (comp_start),
        .comp_timestep    (comp_timestep),
        .comp_done        (comp_done),
        .busy             (busy),
        .err              (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // Reference model: which rows are present, which timestep, and a phase
    // (0 loading, 1 start cycle, 2 waiting for done).
    bit          m_fhave[4];
    bit          m_ihave[4];
    bit          m_ts;
    int          m_phase;
    bit          m_acc;
    bit          e_fwe, e_iwe, e_err, e_start, e_cts, e_busy;
    logic [1:0]    e_row;
    logic [DW-1:0] e_data;

    function automatic bit m_complete();
        for (int i = 0; i < NUM_ROWS; i++)
            if (!m_fhave[i] || !m_ihave[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_ready();
        return rst_n && (m_phase == 0) && !m_complete();
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin m_fhave[i] = 0; m_ihave[i] = 0; end
            m_ts = 0; m_phase = 0;
            e_fwe = 0; e_iwe = 0; e_err = 0; e_start = 0; e_cts = 0; e_busy = 0;
            e_row = '0; e_data = '0;
        end else begin
            m_acc = in_valid && m_ready();
            e_fwe = 0; e_iwe = 0; e_err = 0; e_start = 0;
            if (m_phase == 0) begin
                if (m_complete()) begin
                    m_phase = 1; e_start = 1; e_cts = m_ts; e_busy = 1;
                end else if (m_acc) begin
                    if (int'(in_filter_row) >= NUM_ROWS || (!in_ifmapb_filter && in_timestep != m_ts)) begin
                        e_err = 1;
                    end else begin
                        e_row = in_filter_row; e_data = in_data;
                        if (in_ifmapb_filter) begin e_fwe = 1; m_fhave[in_filter_row] = 1; end
                        else begin e_iwe = 1; m_ihave[in_filter_row] = 1; end
                    end
                end
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else if (comp_done) begin
                m_phase = 0; e_busy = 0;
                for (int i = 0; i < 4; i++) m_ihave[i] = 0;
                if (int'(m_ts) == TIMESTEPS - 1) begin
                    m_ts = 0;
                    for (int i = 0; i < 4; i++) m_fhave[i] = 0;
                end else begin
                    m_ts = 1;
                end
            end
        end
    end

    int            n_start = 0, n_err = 0, n_fwe = 0;
    logic          last_cts = 1'b0;
    logic [DW-1:0] last_row1_data = '0;

    always @(posedge clk) begin
        #1;
        chk("in_ready", in_ready, m_ready());
        chk("filt_we", filt_we, e_fwe);
        chk("ifmap_we", ifmap_we, e_iwe);
        chk("err", err, e_err);
        chk("comp_start", comp_start, e_start);
        chk("comp_timestep", comp_timestep, e_cts);
        chk("busy", busy, e_busy);
        if (e_fwe || e_iwe) begin
            chk("wr_row", wr_row, e_row);
            chk("wr_data", wr_data, e_data);
        end
        if (comp_start) begin n_start++; last_cts = comp_timestep; end
        if (err) n_err++;
        if (filt_we) begin
            n_fwe++;
            if (wr_row == 2'd1) last_row1_data = wr_data;
        end
    end

    task automatic send(input logic f, input logic [1:0] row, input logic ts, input logic [DW-1:0] d);
        in_valid = 1'b1; in_ifmapb_filter = f; in_filter_row = row; in_timestep = ts; in_data = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic load_rows(input logic f, input logic ts);
        for (int r = 0; r < NUM_ROWS; r++) send(f, 2'(r), ts, DW'($urandom));
    endtask

    task automatic finish_compute(input string tag);
        int k = 0;
        in_valid = 1'b0;
        while (!busy && k < 20) begin @(negedge clk); k++; end
        chk({tag, "_start_timeout"}, busy, 1);
        repeat (3) @(negedge clk);
        comp_done = 1'b1;
        @(negedge clk);
        comp_done = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fwe0;
        rst_n = 1'b0; in_valid = 0; in_ifmapb_filter = 0; in_filter_row = 0;
        in_timestep = 0; in_data = '0; comp_done = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Full first load, timestep 0
        load_rows(1'b1, 1'b0);
        load_rows(1'b0, 1'b0);
        finish_compute("t1");
        chk("t1_n_start", n_start, 1);
        chk("t1_cts", last_cts, 0);

        // Timestep 1 reuses filter
        load_rows(1'b0, 1'b1);
        finish_compute("t2");
        chk("t2_n_start", n_start, 2);
        chk("t2_cts", last_cts, 1);

        // New layer: ifmap alone is not enough
        load_rows(1'b0, 1'b0);
        idle(5);
        chk("t3_no_start", n_start, 2);
        load_rows(1'b1, 1'b0);
        finish_compute("t3");
        chk("t3_n_start", n_start, 3);
        chk("t3_cts", last_cts, 0);

        load_rows(1'b0, 1'b1);
        finish_compute("t3b");
        chk("t3b_n_start", n_start, 4);

        // Dropped packets, then partial load
        fwe0 = n_fwe;
        send(1'b1, 2'd3, 1'b0, 24'h0000aa);
        send(1'b0, 2'd0, 1'b1, 24'h0000bb);
        idle(2);
        chk("t4_n_err", n_err, 2);
        chk("t4_no_fwe", n_fwe, fwe0);
        send(1'b1, 2'd0, 1'b0, 24'h101010);
        load_rows(1'b0, 1'b0);
        idle(5);
        chk("t4_no_early_start", n_start, 4);

        // Duplicate filter row 1: A then B
        fwe0 = n_fwe;
        send(1'b1, 2'd1, 1'b0, 24'hA1A1A1);
        send(1'b1, 2'd1, 1'b0, 24'hB2B2B2);
        idle(3);
        chk("t5_still_no_start", n_start, 4);
        send(1'b1, 2'd2, 1'b0, 24'h222222);
        finish_compute("t5");
        chk("t5_fwe_count", n_fwe - fwe0, 3);
        chk("t5_row1_data", last_row1_data, 24'hB2B2B2);
        chk("t5_n_start", n_start, 5);

        // Reset in WAIT (timestep 1 in flight)
        load_rows(1'b0, 1'b1);
        begin
            int k = 0;
            while (!busy && k < 20) begin @(negedge clk); k++; end
        end
        repeat (2) @(negedge clk);
        chk("t6_ts_before_reset", comp_timestep, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_ready", in_ready, 0);
        chk("t6_rst_cts", comp_timestep, 0);
        chk("t6_rst_wr", {wr_row, wr_data, filt_we, ifmap_we, comp_start, err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        comp_done = 1'b1; @(negedge clk); comp_done = 1'b0;
        load_rows(1'b0, 1'b0);
        idle(5);
        chk("t6_no_start", n_start, 6);
        load_rows(1'b1, 1'b0);
        finish_compute("t6");
        chk("t6_n_start", n_start, 7);
        chk("t6_cts", last_cts, 0);

        // Random traffic
        for (int i = 0; i < 1000; i++) begin
            in_valid         = ($urandom_range(0, 3) != 0);
            in_ifmapb_filter = 1'($urandom);
            in_filter_row    = 2'($urandom_range(0, 3));
            in_timestep      = 1'($urandom);
            in_data          = DW'($urandom);
            comp_done        = busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            @(negedge clk);
        end
        in_valid = 0; comp_done = 0;
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
